// File: rtl/fcpu_pkg.sv
// Shared types and constants for the CRAM read path: requester identity,
// route-FIFO entry layout and the fixed AXI attributes of every CRAM read.
package fcpu_pkg;

    typedef enum logic {SRC_FETCH = 1'b0, SRC_LOAD = 1'b1} cram_src_t;

    typedef struct packed {
        cram_src_t src;
        logic      discard;
    } cram_route_t;

    typedef enum logic {ARB_OPEN = 1'b0, ARB_LOCKED = 1'b1} cram_arb_state_t;

    localparam logic [2:0] CRAM_ARSIZE       = 3'd2;
    localparam logic [1:0] CRAM_ARBURST_INCR = 2'd1;

    function automatic logic src_flushed(cram_src_t src, logic flush_fetch, logic flush_load);
        return (src == SRC_FETCH) ? flush_fetch : flush_load;
    endfunction

endpackage

// File: rtl/cram_route_fifo.sv
// In-order record of which requester owns each outstanding CRAM read, with
// per-requester flush marking so stale responses are dropped at the head.
module cram_route_fifo
    import fcpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cram_route_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    input  logic   flush_fetch,
    input  logic   flush_load,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    entry_t             push_marked;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    always_comb begin
        push_marked = push_entry;
        push_marked.discard = push_entry.discard
                            | src_flushed(push_entry.src, flush_fetch, flush_load);
    end

    // NOTE: storage is not reset; an entry only has meaning while count covers it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (src_flushed(mem[i].src, flush_fetch, flush_load))
                mem[i].discard <= 1'b1;
        end
        if (push)
            mem[wr_ptr] <= push_marked;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A flush in the current cycle must already hide the head beat.
    always_comb begin
        head = mem[rd_ptr];
        head.discard = mem[rd_ptr].discard
                     | src_flushed(mem[rd_ptr].src, flush_fetch, flush_load);
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cram_read_arbiter.sv
// Round-robin sharing of the CRAM AXI4 read port between instruction fetch and
// the load/debug reader; responses are steered back through the route FIFO.
module cram_read_arbiter
    import fcpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] f_araddr,
    input  logic              f_arvalid,
    output logic              f_arready,
    input  logic              f_flush,
    output logic [DATA_W-1:0] f_rdata,
    output logic [1:0]        f_rresp,
    output logic              f_rvalid,
    input  logic [ADDR_W-1:0] l_araddr,
    input  logic              l_arvalid,
    output logic              l_arready,
    input  logic              l_flush,
    output logic [DATA_W-1:0] l_rdata,
    output logic [1:0]        l_rresp,
    output logic              l_rvalid,
    input  logic              l_rready,
    output logic [3:0]        m_cram_arid,
    output logic [7:0]        m_cram_arlen,
    output logic [2:0]        m_cram_arsize,
    output logic [1:0]        m_cram_arburst,
    output logic              m_cram_arlock,
    output logic [3:0]        m_cram_arcache,
    output logic [2:0]        m_cram_arprot,
    output logic [3:0]        m_cram_arqos,
    output logic [ADDR_W-1:0] m_cram_araddr,
    output logic              m_cram_arvalid,
    input  logic              m_cram_arready,
    input  logic [DATA_W-1:0] m_cram_rdata,
    input  logic [1:0]        m_cram_rresp,
    input  logic              m_cram_rlast,
    input  logic [3:0]        m_cram_rid,
    input  logic              m_cram_rvalid,
    output logic              m_cram_rready
);
    cram_arb_state_t state, next_state;
    cram_src_t       lock_src, next_lock_src;
    cram_src_t       rr_last, next_rr_last;
    cram_src_t       grant;
    logic            gnt_valid;
    logic            ar_hs;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    cram_route_t     push_entry;
    cram_route_t     head;
    logic            unused_rid;

    assign m_cram_arid    = 4'd0;
    assign m_cram_arlen   = 8'd0;
    assign m_cram_arsize  = CRAM_ARSIZE;
    assign m_cram_arburst = CRAM_ARBURST_INCR;
    assign m_cram_arlock  = 1'b0;
    assign m_cram_arcache = 4'd0;
    assign m_cram_arprot  = 3'd0;
    assign m_cram_arqos   = 4'd0;
    assign unused_rid     = ^m_cram_rid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_OPEN;
            lock_src <= SRC_FETCH;
            rr_last  <= SRC_LOAD;
        end else begin
            state    <= next_state;
            lock_src <= next_lock_src;
            rr_last  <= next_rr_last;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state    = state;
        next_lock_src = lock_src;
        next_rr_last  = rr_last;
        grant         = SRC_FETCH;

        if (state == ARB_LOCKED)
            grant = lock_src;
        else if (f_arvalid && l_arvalid)
            grant = (rr_last == SRC_FETCH) ? SRC_LOAD : SRC_FETCH;
        else if (l_arvalid)
            grant = SRC_LOAD;

        gnt_valid      = (grant == SRC_FETCH) ? f_arvalid : l_arvalid;
        m_cram_arvalid = gnt_valid && !fifo_full;
        m_cram_araddr  = (grant == SRC_FETCH) ? f_araddr : l_araddr;
        ar_hs          = m_cram_arvalid && m_cram_arready;
        f_arready      = ar_hs && (grant == SRC_FETCH);
        l_arready      = ar_hs && (grant == SRC_LOAD);

        // A presented but unaccepted address must stay stable until taken.
        if (ar_hs) begin
            next_state   = ARB_OPEN;
            next_rr_last = grant;
        end else if (m_cram_arvalid) begin
            next_state    = ARB_LOCKED;
            next_lock_src = grant;
        end
    end

    assign push_entry = '{src: grant, discard: 1'b0};

    cram_route_fifo #(
        .DEPTH   (OUTSTANDING),
        .entry_t (cram_route_t)
    ) u_route_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (ar_hs),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .flush_fetch (f_flush),
        .flush_load  (l_flush),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_comb begin
        f_rvalid      = 1'b0;
        l_rvalid      = 1'b0;
        m_cram_rready = 1'b0;
        if (!fifo_empty) begin
            if (head.discard) begin
                m_cram_rready = 1'b1;
            end else if (head.src == SRC_FETCH) begin
                f_rvalid      = m_cram_rvalid;
                m_cram_rready = 1'b1;
            end else begin
                l_rvalid      = m_cram_rvalid;
                m_cram_rready = l_rready;
            end
        end
    end

    assign fifo_pop = m_cram_rvalid && m_cram_rready && m_cram_rlast;
    assign f_rdata  = m_cram_rdata;
    assign f_rresp  = m_cram_rresp;
    assign l_rdata  = m_cram_rdata;
    assign l_rresp  = m_cram_rresp;

    rvalid_needs_route: assert property (@(posedge clk) disable iff (rst)
        m_cram_rvalid |-> !fifo_empty);

endmodule

// File: tb/tb_cram_read_arbiter.sv
// Randomized bench for cram_read_arbiter: a transaction-level model of the
// shared port (in-flight queue + round-robin rule) predicts every output.
module tb_cram_read_arbiter;
    localparam int OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_araddr, l_araddr;
    logic        f_arvalid, l_arvalid, f_flush, l_flush, l_rready;
    logic        f_arready, l_arready, f_rvalid, l_rvalid;
    logic [31:0] f_rdata, l_rdata;
    logic [1:0]  f_rresp, l_rresp;
    logic [3:0]  m_cram_arid, m_cram_arcache, m_cram_arqos;
    logic [7:0]  m_cram_arlen;
    logic [2:0]  m_cram_arsize, m_cram_arprot;
    logic [1:0]  m_cram_arburst;
    logic        m_cram_arlock;
    logic [31:0] m_cram_araddr;
    logic        m_cram_arvalid, m_cram_arready;
    logic [31:0] m_cram_rdata;
    logic [1:0]  m_cram_rresp;
    logic        m_cram_rlast, m_cram_rvalid, m_cram_rready;
    logic [3:0]  m_cram_rid;

    cram_read_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTSTANDING(OUT)) dut (
        .clk(clk), .rst(rst),
        .f_araddr(f_araddr), .f_arvalid(f_arvalid), .f_arready(f_arready), .f_flush(f_flush),
        .f_rdata(f_rdata), .f_rresp(f_rresp), .f_rvalid(f_rvalid),
        .l_araddr(l_araddr), .l_arvalid(l_arvalid), .l_arready(l_arready), .l_flush(l_flush),
        .l_rdata(l_rdata), .l_rresp(l_rresp), .l_rvalid(l_rvalid), .l_rready(l_rready),
        .m_cram_arid(m_cram_arid), .m_cram_arlen(m_cram_arlen), .m_cram_arsize(m_cram_arsize),
        .m_cram_arburst(m_cram_arburst), .m_cram_arlock(m_cram_arlock), .m_cram_arcache(m_cram_arcache),
        .m_cram_arprot(m_cram_arprot), .m_cram_arqos(m_cram_arqos),
        .m_cram_araddr(m_cram_araddr), .m_cram_arvalid(m_cram_arvalid), .m_cram_arready(m_cram_arready),
        .m_cram_rdata(m_cram_rdata), .m_cram_rresp(m_cram_rresp), .m_cram_rlast(m_cram_rlast),
        .m_cram_rid(m_cram_rid), .m_cram_rvalid(m_cram_rvalid), .m_cram_rready(m_cram_rready)
    );

    always #5 clk = ~clk;

    // One in-flight read: owner (0 fetch, 1 load), address, dropped by flush,
    // and the cycle from which the slave model presents its data.
    typedef struct {
        bit          src;
        logic [31:0] addr;
        bit          dropped;
        int          ready_cyc;
    } flight_t;

    flight_t     q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          tail_ready = 0;
    bit          f_pend, l_pend, last_src, stall_prev, stall_src;
    logic [31:0] f_addr, l_addr;
    int          p_fv, p_lv, p_ar, p_lr, p_fl, lat_min, lat_max;

    function automatic logic [31:0] data_of(logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ {15'd0, a[16], 16'd0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        f_pend = 0; l_pend = 0; last_src = 1; stall_prev = 0; stall_src = 0;
        tail_ready = 0;
    endtask

    task automatic drive_idle();
        f_arvalid = 0; l_arvalid = 0; f_araddr = '0; l_araddr = '0;
        f_flush = 0; l_flush = 0; l_rready = 0;
        m_cram_arready = 0; m_cram_rvalid = 0; m_cram_rdata = '0;
        m_cram_rresp = '0; m_cram_rlast = 0; m_cram_rid = '0;
    endtask

    task automatic cycle();
        bit exp_arv, src, both, hs, exp_rr, exp_fv, exp_lv, popped;
        int lat, rdy;
        @(negedge clk);
        cyc++;
        if (!f_pend && $urandom_range(99) < p_fv) begin
            f_pend = 1; f_addr = $urandom & 32'h0000_FFFC;
        end
        if (!l_pend && $urandom_range(99) < p_lv) begin
            l_pend = 1; l_addr = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
        end
        f_arvalid = f_pend; f_araddr = f_addr;
        l_arvalid = l_pend; l_araddr = l_addr;
        f_flush = ($urandom_range(99) < p_fl);
        l_flush = ($urandom_range(99) < p_fl);
        l_rready = ($urandom_range(99) < p_lr);
        m_cram_arready = ($urandom_range(99) < p_ar);
        m_cram_rid = 4'($urandom);
        m_cram_rlast = 1;
        if (q.size() > 0 && q[0].ready_cyc <= cyc) begin
            m_cram_rvalid = 1;
            m_cram_rdata = data_of(q[0].addr);
            m_cram_rresp = q[0].addr[3:2];
        end else begin
            m_cram_rvalid = 0;
            m_cram_rdata = $urandom;
            m_cram_rresp = 2'($urandom);
        end
        #1;
        // Address channel: grant rule and fullness from the in-flight count.
        both = f_pend && l_pend;
        exp_arv = (f_pend || l_pend) && (q.size() < OUT);
        if (stall_prev) src = stall_src;
        else if (both)  src = !last_src;
        else            src = l_pend;
        check("arvalid", 64'(m_cram_arvalid), 64'(exp_arv));
        if (exp_arv)
            check("araddr", 64'(m_cram_araddr), 64'(src ? l_addr : f_addr));
        hs = exp_arv && m_cram_arready;
        check("f_arready", 64'(f_arready), 64'(hs && !src));
        check("l_arready", 64'(l_arready), 64'(hs && src));
        // Flush drops everything already in flight for that requester, head included.
        foreach (q[i])
            if ((q[i].src == 0 && f_flush) || (q[i].src == 1 && l_flush))
                q[i].dropped = 1;
        exp_fv = 0; exp_lv = 0; exp_rr = 0;
        if (q.size() > 0) begin
            if (q[0].dropped)     exp_rr = 1;
            else if (!q[0].src) begin exp_rr = 1; exp_fv = m_cram_rvalid; end
            else begin exp_rr = l_rready; exp_lv = m_cram_rvalid; end
        end
        check("rready", 64'(m_cram_rready), 64'(exp_rr));
        check("f_rvalid", 64'(f_rvalid), 64'(exp_fv));
        check("l_rvalid", 64'(l_rvalid), 64'(exp_lv));
        if (exp_fv) begin
            check("f_rdata", 64'(f_rdata), 64'(data_of(q[0].addr)));
            check("f_rresp", 64'(f_rresp), 64'(q[0].addr[3:2]));
        end
        if (exp_lv) begin
            check("l_rdata", 64'(l_rdata), 64'(data_of(q[0].addr)));
            check("l_rresp", 64'(l_rresp), 64'(q[0].addr[3:2]));
        end
        popped = m_cram_rvalid && exp_rr;
        if (popped) void'(q.pop_front());
        if (hs) begin
            lat = $urandom_range(lat_max, lat_min);
            rdy = (tail_ready > cyc + lat) ? tail_ready : cyc + lat;
            tail_ready = rdy;
            q.push_back('{src: src, addr: (src ? l_addr : f_addr),
                          dropped: (src ? l_flush : f_flush), ready_cyc: rdy});
            if (src) l_pend = 0; else f_pend = 0;
            last_src = src;
            stall_prev = 0;
        end else begin
            stall_prev = exp_arv;
            stall_src = src;
        end
    endtask

    task automatic run(input int n, input int fv, input int lv, input int ar, input int lr,
                       input int fl, input int lmin, input int lmax);
        p_fv = fv; p_lv = lv; p_ar = ar; p_lr = lr; p_fl = fl; lat_min = lmin; lat_max = lmax;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs();
        check("rst_arvalid", 64'(m_cram_arvalid), 64'd0);
        check("rst_rready", 64'(m_cram_rready), 64'd0);
        check("rst_f_rvalid", 64'(f_rvalid), 64'd0);
        check("rst_l_rvalid", 64'(l_rvalid), 64'd0);
        check("rst_f_arready", 64'(f_arready), 64'd0);
        check("rst_l_arready", 64'(l_arready), 64'd0);
        check("rst_araddr", 64'(m_cram_araddr), 64'd0);
    endtask

    initial begin
        drive_idle();
        model_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        check("arid", 64'(m_cram_arid), 64'd0);
        check("arlen", 64'(m_cram_arlen), 64'd0);
        check("arsize", 64'(m_cram_arsize), 64'd2);
        check("arburst", 64'(m_cram_arburst), 64'd1);
        check("arlock_cache_prot_qos",
              64'({m_cram_arlock, m_cram_arcache, m_cram_arprot, m_cram_arqos}), 64'd0);
        rst = 0;

        // Fetch-only stream, fixed two-cycle return.
        run(60, 90, 0, 100, 100, 0, 2, 2);
        // Both requesters always valid: strict alternation.
        run(80, 100, 100, 100, 100, 0, 1, 3);
        // Address back-pressure, load back-pressure and occasional flushes.
        run(300, 70, 70, 40, 60, 5, 1, 4);
        // Long response latency keeps the route FIFO full.
        run(200, 95, 95, 90, 80, 0, 8, 15);
        // Everything at once, heavier flushing.
        run(400, 60, 60, 60, 50, 15, 1, 10);

        // Reset while traffic is in flight.
        @(negedge clk);
        rst = 1;
        drive_idle();
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 0;

        run(300, 80, 80, 70, 70, 8, 1, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
